// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential fetch, branch/jump redirects with pipeline flushes, misaligned-target trap.
// Optional performance counters (redirect_cnt, stall_cnt) are enabled by defining PC_PERF_CNT_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_req,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        misaligned
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        flush_if_c, flush_id_c;
  logic        tgt_mis;
  logic        accept;
  logic        held;

  assign tgt_mis = (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    accept     = 1'b0;
    held       = 1'b0;

    if (state_q == S_TRAP) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (redirect_valid && tgt_mis) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
      pend_vld_d = 1'b0;
      state_d    = S_TRAP;
    end else if (redirect_valid) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
      // A buffered older redirect wins; the new one only contributes its flushes.
      if (pend_vld_q) begin
        if (fetch_ready) begin
          pc_d       = pend_pc_q;
          pend_vld_d = 1'b0;
          state_d    = S_FLUSH;
        end else begin
          held    = 1'b1;
          state_d = S_WAIT;
        end
      end else if (fetch_ready) begin
        pc_d    = redirect_target;
        accept  = 1'b1;
        state_d = S_FLUSH;
      end else begin
        pend_vld_d = 1'b1;
        pend_pc_d  = redirect_target;
        accept     = 1'b1;
        held       = 1'b1;
        state_d    = S_WAIT;
      end
    end else begin
      if (state_q == S_FLUSH) flush_if_c = 1'b1;
      if (pend_vld_q) begin
        if (fetch_ready) begin
          pc_d       = pend_pc_q;
          pend_vld_d = 1'b0;
          state_d    = S_FLUSH;
        end else begin
          held    = 1'b1;
          state_d = S_WAIT;
        end
      end else if (!fetch_ready) begin
        held    = 1'b1;
        state_d = S_WAIT;
      end else if (stall_req && (state_q == S_RUN)) begin
        held = 1'b1;
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = !rst && (state_q != S_TRAP);
  assign flush_if    = !rst && flush_if_c;
  assign flush_id    = !rst && flush_id_c;
  assign misaligned  = !rst && ((state_q == S_TRAP) || (redirect_valid && tgt_mis));

`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q + {31'd0, accept};
    stall_cnt_d    = stall_cnt_q + {31'd0, held};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: stimulus pushes expected outputs, a negedge monitor compares.
module tb_pc_redirect_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        fi;
    logic        fd;
    logic        mis;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall_req;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if;
  logic        flush_id;
  logic        misaligned;
`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb_q[$];
  logic [7:0]  step_no = '0;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .stall_req(stall_req),
    .fetch_ready(fetch_ready),
    .pc(pc),
    .fetch_valid(fetch_valid),
    .flush_if(flush_if),
    .flush_id(flush_id),
    .misaligned(misaligned)
`ifdef PC_PERF_CNT_EN
    ,
    .redirect_cnt(redirect_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, record what the outputs must show this cycle, advance past the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] tgt, input logic st,
                      input logic fr, input logic [31:0] e_pc, input logic e_fv,
                      input logic e_fi, input logic e_fd, input logic e_mis);
    exp_t e;
    rst             = r;
    redirect_valid  = rv;
    redirect_target = tgt;
    stall_req       = st;
    fetch_ready     = fr;
    step_no         = step_no + 8'd1;
    e = '{pc: e_pc, fv: e_fv, fi: e_fi, fd: e_fd, mis: e_mis, tag: step_no};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks = checks + 1;
      if ({pc, fetch_valid, flush_if, flush_id, misaligned} !== {e.pc, e.fv, e.fi, e.fd, e.mis}) begin
        errors = errors + 1;
        $display("FAIL step%0d: got pc=%h fv=%b fi=%b fd=%b mis=%b, expected pc=%h fv=%b fi=%b fd=%b mis=%b",
                 e.tag, pc, fetch_valid, flush_if, flush_id, misaligned,
                 e.pc, e.fv, e.fi, e.fd, e.mis);
      end
    end
  end

  initial begin
    // Reset state
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 1, 32'h0, 0, 0, 0, 0);
    // Sequential fetch 0,4,8,C
    step(0, 0, 32'h0, 0, 1, 32'h0, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h4, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h8, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'hC, 1, 0, 0, 0);
    // Redirect at 0x10 -> 0x100, FLUSH, then 0x104
    step(0, 1, 32'h100, 0, 1, 32'h10, 1, 1, 1, 0);
    step(0, 0, 32'h0, 0, 1, 32'h100, 1, 1, 0, 0);
`ifdef PC_PERF_CNT_EN
    checks = checks + 1;
    if (redirect_cnt !== 32'd1) begin
      errors = errors + 1;
      $display("FAIL redirect_cnt: got %0d, expected 1", redirect_cnt);
    end
`endif
    step(0, 1, 32'h1C, 0, 1, 32'h104, 1, 1, 1, 0);
    step(0, 0, 32'h0, 0, 1, 32'h1C, 1, 1, 0, 0);
    // Pending buffer: 0x200 captured, 0x300 ignored, pc held at 0x20
    step(0, 1, 32'h200, 0, 0, 32'h20, 1, 1, 1, 0);
    step(0, 1, 32'h300, 0, 0, 32'h20, 1, 1, 1, 0);
    step(0, 0, 32'h0, 0, 0, 32'h20, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h20, 1, 0, 0, 0);
    // Redirect inside FLUSH restarts FLUSH
    step(0, 1, 32'h3C, 0, 1, 32'h200, 1, 1, 1, 0);
    step(0, 0, 32'h0, 0, 1, 32'h3C, 1, 1, 0, 0);
    // Stall holds for three cycles; stall with redirect still redirects
    step(0, 0, 32'h0, 1, 1, 32'h40, 1, 0, 0, 0);
    step(0, 0, 32'h0, 1, 1, 32'h40, 1, 0, 0, 0);
    step(0, 0, 32'h0, 1, 1, 32'h40, 1, 0, 0, 0);
    step(0, 1, 32'h80, 1, 1, 32'h40, 1, 1, 1, 0);
    step(0, 0, 32'h0, 1, 1, 32'h80, 1, 1, 0, 0);
    // Misaligned target -> TRAP, held until reset
    step(0, 1, 32'h102, 0, 1, 32'h84, 1, 1, 1, 1);
    step(0, 0, 32'h0, 0, 1, 32'h84, 0, 1, 1, 1);
    step(0, 1, 32'h500, 0, 1, 32'h84, 0, 1, 1, 1);
    step(1, 0, 32'h0, 0, 1, 32'h0, 0, 0, 0, 0);
    // Wrap-around at the top of the address space
    step(0, 1, 32'hFFFF_FFF8, 0, 1, 32'h0, 1, 1, 1, 0);
    step(0, 0, 32'h0, 0, 1, 32'hFFFF_FFF8, 1, 1, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    // WAIT ignores stall once fetch_ready returns
    step(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0);
    step(0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0, 0);
    step(0, 0, 32'h0, 1, 1, 32'h0, 1, 0, 0, 0);
    // Reset mid-WAIT discards the pending redirect
    step(0, 1, 32'h600, 0, 0, 32'h4, 1, 1, 1, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h0, 1, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h4, 1, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
